// File: rtl/register_bus_pkg.sv
// Shared types and defaults for the register bus arbiter.
//   state_t  : arbiter FSM states
//   master_t : identity of the two bus masters (M0 = ulisp core, M1 = debug/host port)
package register_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RESPOND = 2'd3
    } state_t;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } master_t;

    localparam int DEFAULT_INDEX_WIDTH = 12;
    localparam int DEFAULT_DATA_WIDTH  = 16;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick (purely combinational).
// Ports:
//   req0, req1  : request lines of master 0 / master 1
//   last_grant  : master that won the previous arbitration
//   grant       : chosen master; only meaningful when req0 or req1 is high
module rr_arbiter2
    import register_bus_pkg::*;
(
    input  logic    req0,
    input  logic    req1,
    input  master_t last_grant,
    output master_t grant
);

    always_comb begin
        grant = M0;
        if (req0 && req1) begin
            // Tie: the master that did not win last time goes next.
            grant = (last_grant == M0) ? M1 : M0;
        end else if (req1) begin
            grant = M1;
        end else begin
            grant = M0;
        end
    end

endmodule

// File: rtl/register_bus_arbiter.sv
// Shares the peripheral register bus between the ulisp core (m0) and the
// debug/host port (m1). One transaction in flight, round-robin grant,
// variable-latency peripherals via register_ready, timeout with a fixed
// read value. Every output is a register.
// Ports:
//   clk, reset_n                    : clock, asynchronous active-low reset
//   mX_req/write/index/wdata        : master request, held stable until ack
//   mX_ack, mX_rdata                : one-cycle completion pulse and read result
//   register_index/read/write       : bus index and single-cycle strobes
//   register_write_value            : bus write data
//   register_read_value, register_ready : peripheral response
//   bus_timeout                     : one-cycle pulse, coincident with the aborted ack
module register_bus_arbiter
    import register_bus_pkg::*;
#(
    parameter int INDEX_WIDTH    = DEFAULT_INDEX_WIDTH,
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 15,
    parameter logic [DATA_WIDTH-1:0] TIMEOUT_VALUE = {DATA_WIDTH{1'b1}}
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   m0_req,
    input  logic                   m0_write,
    input  logic [INDEX_WIDTH-1:0] m0_index,
    input  logic [DATA_WIDTH-1:0]  m0_wdata,
    output logic                   m0_ack,
    output logic [DATA_WIDTH-1:0]  m0_rdata,
    input  logic                   m1_req,
    input  logic                   m1_write,
    input  logic [INDEX_WIDTH-1:0] m1_index,
    input  logic [DATA_WIDTH-1:0]  m1_wdata,
    output logic                   m1_ack,
    output logic [DATA_WIDTH-1:0]  m1_rdata,
    output logic [INDEX_WIDTH-1:0] register_index,
    output logic                   register_read,
    output logic                   register_write,
    output logic [DATA_WIDTH-1:0]  register_write_value,
    input  logic [DATA_WIDTH-1:0]  register_read_value,
    input  logic                   register_ready,
    output logic                   bus_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_CYCLES);

    state_t                         state_reg,      state_next;
    logic [CNT_W-1:0]               cnt_reg,        cnt_next;
    master_t                        last_grant_reg, last_grant_next;
    master_t                        owner_reg,      owner_next;
    logic                           write_reg,      write_next;
    logic [INDEX_WIDTH-1:0]         index_reg,      index_next;
    logic [DATA_WIDTH-1:0]          wvalue_reg,     wvalue_next;
    logic                           rd_stb_reg,     rd_stb_next;
    logic                           wr_stb_reg,     wr_stb_next;
    logic [1:0]                     ack_reg,        ack_next;
    logic [1:0][DATA_WIDTH-1:0]     rdata_reg,      rdata_next;
    logic                           timeout_reg,    timeout_next;

    master_t pick;

    rr_arbiter2 u_rr (
        .req0       (m0_req),
        .req1       (m1_req),
        .last_grant (last_grant_reg),
        .grant      (pick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            last_grant_reg <= M1;       // m0 wins the first tie
            owner_reg      <= M0;
            write_reg      <= 1'b0;
            index_reg      <= '0;
            wvalue_reg     <= '0;
            rd_stb_reg     <= 1'b0;
            wr_stb_reg     <= 1'b0;
            ack_reg        <= '0;
            rdata_reg      <= '0;
            timeout_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            last_grant_reg <= last_grant_next;
            owner_reg      <= owner_next;
            write_reg      <= write_next;
            index_reg      <= index_next;
            wvalue_reg     <= wvalue_next;
            rd_stb_reg     <= rd_stb_next;
            wr_stb_reg     <= wr_stb_next;
            ack_reg        <= ack_next;
            rdata_reg      <= rdata_next;
            timeout_reg    <= timeout_next;
        end
    end

    // The *_next strobe/ack/rdata values are what the bus sees in the
    // following cycle, so each transition sets up the outputs of the state
    // being entered.
    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        last_grant_next = last_grant_reg;
        owner_next      = owner_reg;
        write_next      = write_reg;
        index_next      = index_reg;
        wvalue_next     = wvalue_reg;
        rd_stb_next     = 1'b0;
        wr_stb_next     = 1'b0;
        ack_next        = '0;
        rdata_next      = '0;
        timeout_next    = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                cnt_next = '0;
                if (m0_req || m1_req) begin
                    owner_next      = pick;
                    last_grant_next = pick;
                    write_next      = (pick == M1) ? m1_write : m0_write;
                    index_next      = (pick == M1) ? m1_index : m0_index;
                    wvalue_next     = (pick == M1) ? m1_wdata : m0_wdata;
                    rd_stb_next     = (pick == M1) ? !m1_write : !m0_write;
                    wr_stb_next     = (pick == M1) ? m1_write : m0_write;
                    cnt_next        = CNT_W'(1);
                    state_next      = ST_ISSUE;
                end
            end

            ST_ISSUE, ST_WAIT: begin
                // Ready takes priority over the timeout in the last allowed cycle.
                if (register_ready) begin
                    state_next            = ST_RESPOND;
                    ack_next[owner_reg]   = 1'b1;
                    rdata_next[owner_reg] = write_reg ? '0 : register_read_value;
                end else if (cnt_reg == TIMEOUT_CNT) begin
                    state_next            = ST_RESPOND;
                    ack_next[owner_reg]   = 1'b1;
                    rdata_next[owner_reg] = TIMEOUT_VALUE;
                    timeout_next          = 1'b1;
                end else begin
                    cnt_next   = cnt_reg + CNT_W'(1);
                    state_next = ST_WAIT;
                end
            end

            ST_RESPOND: begin
                // One cycle here lets the master drop req before IDLE samples it.
                cnt_next   = '0;
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign register_index       = index_reg;
    assign register_write_value = wvalue_reg;
    assign register_read        = rd_stb_reg;
    assign register_write       = wr_stb_reg;
    assign bus_timeout          = timeout_reg;
    assign m0_ack               = ack_reg[0];
    assign m1_ack               = ack_reg[1];
    assign m0_rdata             = rdata_reg[0];
    assign m1_rdata             = rdata_reg[1];

endmodule

// File: tb/tb_register_bus_arbiter.sv
// Directed bench for register_bus_arbiter: a table of single-master
// transactions plus hand-written sequences for fairness, a request arriving
// mid-transaction, and reset during a wait.
module tb_register_bus_arbiter;

    localparam int IW = 12;
    localparam int DW = 16;
    localparam int NEVER = 1000;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          m0_req = 1'b0, m0_write = 1'b0;
    logic [IW-1:0] m0_index = '0;
    logic [DW-1:0] m0_wdata = '0;
    logic          m0_ack;
    logic [DW-1:0] m0_rdata;
    logic          m1_req = 1'b0, m1_write = 1'b0;
    logic [IW-1:0] m1_index = '0;
    logic [DW-1:0] m1_wdata = '0;
    logic          m1_ack;
    logic [DW-1:0] m1_rdata;
    logic [IW-1:0] register_index;
    logic          register_read, register_write;
    logic [DW-1:0] register_write_value;
    logic [DW-1:0] register_read_value = '0;
    logic          register_ready = 1'b0;
    logic          bus_timeout;

    register_bus_arbiter dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .m0_req               (m0_req),
        .m0_write             (m0_write),
        .m0_index             (m0_index),
        .m0_wdata             (m0_wdata),
        .m0_ack               (m0_ack),
        .m0_rdata             (m0_rdata),
        .m1_req               (m1_req),
        .m1_write             (m1_write),
        .m1_index             (m1_index),
        .m1_wdata             (m1_wdata),
        .m1_ack               (m1_ack),
        .m1_rdata             (m1_rdata),
        .register_index       (register_index),
        .register_read        (register_read),
        .register_write       (register_write),
        .register_write_value (register_write_value),
        .register_read_value  (register_read_value),
        .register_ready       (register_ready),
        .bus_timeout          (bus_timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    typedef struct {
        int            m;
        logic          wr;
        logic [IW-1:0] idx;
        logic [DW-1:0] wd;
        int            waits;      // wait cycles before ready; NEVER = no ready
        logic [DW-1:0] pval;       // peripheral data offered on the ready cycle
        logic [DW-1:0] exp_rdata;
        int            exp_lat;    // cycles from req sample edge-1 to ack
        int            exp_to;
    } vec_t;

    vec_t vecs[8];

    // Runs one transaction from an IDLE cycle; returns observations.
    task automatic run_txn(input vec_t v, output int lat, output int rd_stb, output int wr_stb,
                           output logic [DW-1:0] rdata, output int to_cnt,
                           output int bad_bus, output int wrong_ack);
        lat = -1; rd_stb = 0; wr_stb = 0; rdata = '0; to_cnt = 0; bad_bus = 0; wrong_ack = 0;
        register_ready = 1'b0;
        if (v.m == 0) begin
            m0_req = 1'b1; m0_write = v.wr; m0_index = v.idx; m0_wdata = v.wd;
        end else begin
            m1_req = 1'b1; m1_write = v.wr; m1_index = v.idx; m1_wdata = v.wd;
        end
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            @(posedge clk); #1;
            rd_stb += int'(register_read);
            wr_stb += int'(register_write);
            to_cnt += int'(bus_timeout);
            if (register_index !== v.idx || (v.wr && register_write_value !== v.wd)) bad_bus++;
            if ((v.m == 0) ? m1_ack : m0_ack) wrong_ack++;
            if ((v.m == 0) ? m0_ack : m1_ack) begin
                lat   = k;
                rdata = (v.m == 0) ? m0_rdata : m1_rdata;
            end
            register_ready      = (k == 1 + v.waits);
            register_read_value = (k == 1 + v.waits) ? v.pval : 16'hDEAD;
        end
        m0_req = 1'b0; m1_req = 1'b0; register_ready = 1'b0;
        $display("txn m%0d %s idx=%h lat=%0d rdata=%h timeouts=%0d",
                 v.m, v.wr ? "wr" : "rd", v.idx, lat, rdata, to_cnt);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        m0_req = 1'b0; m1_req = 1'b0; register_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        int lat, rd, wr, to, bad, wack;
        logic [DW-1:0] rdata;
        int order[4];
        int n, both, m0_low, m1_low;
        int m0_ack_k, m1_ack_k, m1_stb_k, m0_stb, idx_bad, to6, acks_in_reset;
        logic [DW-1:0] m1_rd;
        vec_t v;

        vecs[0] = '{0, 1'b1, 12'h000, 16'h0041, 0,     16'h0000, 16'h0000, 2,  0};
        vecs[1] = '{1, 1'b0, 12'h005, 16'h0000, 3,     16'h1234, 16'h1234, 5,  0};
        vecs[2] = '{0, 1'b0, 12'h007, 16'h0000, NEVER, 16'h0000, 16'hFFFF, 16, 1};
        vecs[3] = '{1, 1'b1, 12'hABC, 16'hBEEF, 2,     16'h0000, 16'h0000, 4,  0};
        vecs[4] = '{0, 1'b0, 12'hFFF, 16'h0000, 14,    16'h5A5A, 16'h5A5A, 16, 0};
        vecs[5] = '{1, 1'b0, 12'h001, 16'h0000, 1,     16'hC3C3, 16'hC3C3, 3,  0};
        vecs[6] = '{1, 1'b0, 12'h123, 16'h0000, NEVER, 16'h0000, 16'hFFFF, 16, 1};
        vecs[7] = '{0, 1'b1, 12'h010, 16'h8001, 5,     16'h0000, 16'h0000, 7,  0};

        // Reset values
        repeat (2) @(posedge clk); #1;
        check("rst_m0_ack", {31'b0, m0_ack}, 0);
        check("rst_m1_ack", {31'b0, m1_ack}, 0);
        check("rst_read", {31'b0, register_read}, 0);
        check("rst_write", {31'b0, register_write}, 0);
        check("rst_index", {20'b0, register_index}, 0);
        check("rst_timeout", {31'b0, bus_timeout}, 0);
        check("rst_rdata", {m0_rdata, m1_rdata}, 0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;

        // Both masters request together right after reset; each re-requests after its ack.
        m0_write = 1'b0; m0_index = 12'h0A0;
        m1_write = 1'b0; m1_index = 12'h0B0;
        register_ready = 1'b1; register_read_value = 16'h0001;
        m0_req = 1'b1; m1_req = 1'b1;
        n = 0; both = 0; m0_low = 0; m1_low = 0;
        for (int c = 0; c < 60 && n < 4; c++) begin
            @(posedge clk); #1;
            if (m0_ack && m1_ack) both++;
            if (m0_low != 0) begin m0_req = 1'b1; m0_low = 0; end
            if (m1_low != 0) begin m1_req = 1'b1; m1_low = 0; end
            if (m0_ack) begin order[n] = 0; n++; m0_req = 1'b0; m0_low = 1; end
            else if (m1_ack) begin order[n] = 1; n++; m1_req = 1'b0; m1_low = 1; end
        end
        m0_req = 1'b0; m1_req = 1'b0; register_ready = 1'b0;
        $display("txn fairness grants=%0d order=%0d%0d%0d%0d", n, order[0], order[1], order[2], order[3]);
        check("rr_count", n, 4);
        check("rr_order0", order[0], 0);
        check("rr_order1", order[1], 1);
        check("rr_order2", order[2], 0);
        check("rr_order3", order[3], 1);
        check("rr_double_ack", both, 0);
        repeat (2) @(posedge clk); #1;

        // Table of single-master transactions
        for (int i = 0; i < 8; i++) begin
            v = vecs[i];
            run_txn(v, lat, rd, wr, rdata, to, bad, wack);
            check($sformatf("v%0d_latency", i), lat, v.exp_lat);
            check($sformatf("v%0d_rdata", i), {16'b0, rdata}, {16'b0, v.exp_rdata});
            check($sformatf("v%0d_read_strobes", i), rd, v.wr ? 0 : 1);
            check($sformatf("v%0d_write_strobes", i), wr, v.wr ? 1 : 0);
            check($sformatf("v%0d_timeouts", i), to, v.exp_to);
            check($sformatf("v%0d_bus_fields", i), bad, 0);
            check($sformatf("v%0d_other_ack", i), wack, 0);
            @(posedge clk); #1;
            check($sformatf("v%0d_ack_pulse", i), {30'b0, m1_ack, m0_ack}, 0);
        end

        // m0 write with 4 wait cycles; m1 read request arrives mid-WAIT.
        m0_req = 1'b1; m0_write = 1'b1; m0_index = 12'h022; m0_wdata = 16'h7777;
        register_read_value = 16'h4242;
        m0_ack_k = -1; m1_ack_k = -1; m1_stb_k = -1; m0_stb = 0; idx_bad = 0; to6 = 0; m1_rd = '0;
        for (int k = 1; k <= 40 && m1_ack_k < 0; k++) begin
            @(posedge clk); #1;
            to6 += int'(bus_timeout);
            if (m0_ack_k < 0) begin
                m0_stb += int'(register_write) + int'(register_read);
                if (register_index !== 12'h022 || register_write_value !== 16'h7777) idx_bad++;
            end else if (register_read && m1_stb_k < 0) begin
                m1_stb_k = k;
            end
            if (m0_ack) begin m0_ack_k = k; m0_req = 1'b0; end
            if (m1_ack) begin m1_ack_k = k; m1_rd = m1_rdata; m1_req = 1'b0; end
            if (k == 3) begin
                m1_req = 1'b1; m1_write = 1'b0; m1_index = 12'h033;
            end
            register_ready = (k == 5) || (k == m1_stb_k);
        end
        register_ready = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
        $display("txn overlap m0_ack@%0d m1_strobe@%0d m1_ack@%0d m1_rdata=%h", m0_ack_k, m1_stb_k, m1_ack_k, m1_rd);
        check("ovl_m0_ack_cycle", m0_ack_k, 6);
        check("ovl_m0_strobes", m0_stb, 1);
        check("ovl_bus_stable", idx_bad, 0);
        check("ovl_m1_strobe_cycle", m1_stb_k, 8);
        check("ovl_m1_ack_cycle", m1_ack_k, 9);
        check("ovl_m1_rdata", {16'b0, m1_rd}, 32'h4242);
        check("ovl_timeouts", to6, 0);
        @(posedge clk); #1;

        // Reset asserted while m0's read is waiting.
        m0_req = 1'b1; m0_write = 1'b0; m0_index = 12'h003;
        register_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b0;
        m0_req = 1'b0;
        #1;
        check("rstw_read", {31'b0, register_read}, 0);
        check("rstw_index", {20'b0, register_index}, 0);
        check("rstw_acks", {30'b0, m1_ack, m0_ack}, 0);
        check("rstw_timeout", {31'b0, bus_timeout}, 0);
        acks_in_reset = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            acks_in_reset += int'(m0_ack) + int'(m1_ack) + int'(bus_timeout);
        end
        check("rstw_quiet", acks_in_reset, 0);
        $display("txn reset during wait, pulses while held=%0d", acks_in_reset);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        v = '{1, 1'b0, 12'h009, 16'h0000, 0, 16'h0F0F, 16'h0F0F, 2, 0};
        run_txn(v, lat, rd, wr, rdata, to, bad, wack);
        check("post_rst_latency", lat, 2);
        check("post_rst_rdata", {16'b0, rdata}, 32'h0F0F);
        check("post_rst_read_strobes", rd, 1);
        check("post_rst_other_ack", wack, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
